// File: rtl/led_seq_pkg.sv
// Shared types and default constants for the LED sequencer.
`timescale 1ns/1ps
package led_seq_pkg;

  // Pattern modes, encoded to match the mode_i select values.
  typedef enum logic [1:0] {
    MODE_WALK   = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BIN    = 2'd2,
    MODE_GRAY   = 2'd3
  } mode_e;

  localparam int unsigned DEF_NUM_LED = 3;
  localparam int unsigned DEF_PWM_W   = 8;
  localparam int unsigned DEF_CNT_W   = 16;

  // Internal BOUNCE travel direction.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_seq_tick_sync.sv
// Two-flop synchroniser for an asynchronous tick, plus a third flop that
// turns each rising edge into a single-cycle strobe.
`timescale 1ns/1ps
module tick_sync (
  input  logic clk100,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic r_sync1;
  logic r_sync2;
  logic r_edge;

  // Synchronise the tick and keep the previous synchronised level.
  always_ff @(posedge clk100) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= async_i;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
    end
  end

  // High for the one cycle after the synchronised level first goes high.
  assign rise_o = r_sync2 & ~r_edge;

endmodule

// File: rtl/led_seq.sv
// LED pattern sequencer: steps a WALK/BOUNCE/BIN/GRAY pattern on each
// synchronised tick and gates the result with a brightness PWM.
`timescale 1ns/1ps
module led_seq
  import led_seq_pkg::*;
#(
  parameter int unsigned NUM_LED = DEF_NUM_LED,
  parameter int unsigned PWM_W   = DEF_PWM_W,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic               clk100,
  input  logic               rst,
  input  logic               tick_i,
  input  logic [1:0]         mode_i,
  input  logic               dir_i,
  input  logic               pause_i,
  input  logic [PWM_W-1:0]   duty_i,
  output logic [NUM_LED-1:0] led_o,
  output logic [CNT_W-1:0]   step_cnt_o,
  output logic [1:0]         mode_o
);

  localparam logic [NUM_LED-1:0] LED_ONE = {{(NUM_LED-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PWM_W-1:0]   PWM_ONE = {{(PWM_W-1){1'b0}}, 1'b1};

  logic               w_step_strobe;
  mode_e              w_mode_req;
  logic               w_mode_chg;
  logic               w_step;
  logic               w_pwm_on;
  logic [NUM_LED-1:0] w_cnt_step;
  logic [NUM_LED-1:0] w_next_pattern;
  logic [NUM_LED-1:0] w_next_cnt;
  logic               w_next_bdir;

  mode_e              r_mode;
  logic [NUM_LED-1:0] r_pattern;
  logic [NUM_LED-1:0] r_cnt;
  logic               r_bdir;
  logic [CNT_W-1:0]   r_step_cnt;
  logic [PWM_W-1:0]   r_pwm_cnt;
  logic [NUM_LED-1:0] r_led;

  tick_sync u_tick_sync (
    .clk100  (clk100),
    .rst     (rst),
    .async_i (tick_i),
    .rise_o  (w_step_strobe)
  );

  // A mode change wins over a coincident step; pause discards steps.
  assign w_mode_req = mode_e'(mode_i);
  assign w_mode_chg = (w_mode_req != r_mode);
  assign w_step     = w_step_strobe & ~pause_i & ~w_mode_chg;
  assign w_cnt_step = dir_i ? (r_cnt - LED_ONE) : (r_cnt + LED_ONE);
  assign w_pwm_on   = (&duty_i) | (r_pwm_cnt < duty_i);

  // Next pattern, BIN/GRAY counter and BOUNCE direction.
  always_comb begin
    w_next_pattern = r_pattern;
    w_next_cnt     = r_cnt;
    w_next_bdir    = r_bdir;
    if (w_mode_chg) begin
      w_next_cnt  = '0;
      w_next_bdir = DIR_LEFT;
      if ((w_mode_req == MODE_WALK) || (w_mode_req == MODE_BOUNCE)) begin
        w_next_pattern = LED_ONE;
      end else begin
        w_next_pattern = '0;
      end
    end else if (w_step) begin
      case (r_mode)
        MODE_WALK: begin
          if (dir_i) begin
            w_next_pattern = {r_pattern[0], r_pattern[NUM_LED-1:1]};
          end else begin
            w_next_pattern = {r_pattern[NUM_LED-2:0], r_pattern[NUM_LED-1]};
          end
        end
        MODE_BOUNCE: begin
          // Reversal and shift happen in the same step at either end.
          if (r_bdir == DIR_LEFT) begin
            if (r_pattern[NUM_LED-1]) begin
              w_next_bdir    = DIR_RIGHT;
              w_next_pattern = r_pattern >> 1;
            end else begin
              w_next_pattern = r_pattern << 1;
            end
          end else begin
            if (r_pattern[0]) begin
              w_next_bdir    = DIR_LEFT;
              w_next_pattern = r_pattern << 1;
            end else begin
              w_next_pattern = r_pattern >> 1;
            end
          end
        end
        MODE_BIN: begin
          w_next_cnt     = w_cnt_step;
          w_next_pattern = w_cnt_step;
        end
        MODE_GRAY: begin
          w_next_cnt     = w_cnt_step;
          w_next_pattern = w_cnt_step ^ (w_cnt_step >> 1);
        end
      endcase
    end
  end

  // State, step counter, PWM counter and gated LED register.
  always_ff @(posedge clk100) begin
    if (rst) begin
      r_mode     <= MODE_WALK;
      r_pattern  <= LED_ONE;
      r_cnt      <= '0;
      r_bdir     <= DIR_LEFT;
      r_step_cnt <= '0;
      r_pwm_cnt  <= '0;
      r_led      <= '0;
    end else begin
      if (w_mode_chg) begin
        r_mode <= w_mode_req;
      end
      r_pattern <= w_next_pattern;
      r_cnt     <= w_next_cnt;
      r_bdir    <= w_next_bdir;
      if (w_step) begin
        r_step_cnt <= r_step_cnt + CNT_ONE;
      end
      r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
      r_led     <= r_pattern & {NUM_LED{w_pwm_on}};
    end
  end

  assign led_o      = r_led;
  assign step_cnt_o = r_step_cnt;
  assign mode_o     = r_mode;

endmodule

// File: tb/tb_led_seq.sv
// Bench for led_seq: directed ticks and mode changes push expected
// {mode, step count, leds} into a queue; a monitor pops on each output event.
`timescale 1ns/1ps
module tb_led_seq;

  localparam int NUM_LED = 3;
  localparam int PWM_W   = 8;
  localparam int CNT_W   = 16;
  localparam int EW      = 2 + CNT_W + NUM_LED;

  // Clock / reset
  logic               clk100 = 1'b0;
  logic               rst    = 1'b1;
  logic               tick_i = 1'b0;
  logic [1:0]         mode_i = 2'd0;
  logic               dir_i  = 1'b0;
  logic               pause_i = 1'b0;
  logic [PWM_W-1:0]   duty_i = 8'hff;
  logic [NUM_LED-1:0] led_o;
  logic [CNT_W-1:0]   step_cnt_o;
  logic [1:0]         mode_o;

  always #5 clk100 = ~clk100;

  led_seq #(.NUM_LED(NUM_LED), .PWM_W(PWM_W), .CNT_W(CNT_W)) dut (
    .clk100     (clk100),
    .rst        (rst),
    .tick_i     (tick_i),
    .mode_i     (mode_i),
    .dir_i      (dir_i),
    .pause_i    (pause_i),
    .duty_i     (duty_i),
    .led_o      (led_o),
    .step_cnt_o (step_cnt_o),
    .mode_o     (mode_o)
  );

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  bit  mon_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] m, input logic [CNT_W-1:0] c, input logic [NUM_LED-1:0] l);
    exp_q.push_back({m, c, l});
  endtask

  // Driver tasks
  task automatic do_tick();
    @(negedge clk100);
    tick_i = 1'b1;
    repeat (3) @(negedge clk100);
    tick_i = 1'b0;
    repeat (5) @(negedge clk100);
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk100);
    mode_i = m;
    repeat (5) @(negedge clk100);
  endtask

  task automatic pwm_count(input logic [PWM_W-1:0] duty, input int exp_on, input string name);
    int on_cnt;
    int bad_cnt;
    @(negedge clk100);
    duty_i = duty;
    repeat (3) @(negedge clk100);
    on_cnt  = 0;
    bad_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk100);
      if (led_o == 3'b001) on_cnt++;
      else if (led_o != 3'b000) bad_cnt++;
    end
    check(name, on_cnt, exp_on);
    check({name, "_other_bits"}, bad_cnt, 0);
  endtask

  // Monitor: an output event is a change of mode_o or step_cnt_o; led_o is
  // compared one cycle later once the registered output has caught up.
  initial begin
    logic [CNT_W+1:0] last;
    logic [EW-1:0]    obs;
    logic [EW-1:0]    e;
    bit               have_last;
    have_last = 1'b0;
    last      = '0;
    forever begin
      @(negedge clk100);
      if (!mon_en) begin
        have_last = 1'b0;
      end else if (!have_last) begin
        last      = {mode_o, step_cnt_o};
        have_last = 1'b1;
      end else if ({mode_o, step_cnt_o} != last) begin
        last = {mode_o, step_cnt_o};
        @(negedge clk100);
        obs = {mode_o, step_cnt_o, led_o};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got %0h expected none", obs);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard", obs, e);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    repeat (3) @(negedge clk100);
    check("reset_led", led_o, 3'b000);
    check("reset_step", step_cnt_o, 0);
    check("reset_mode", mode_o, 0);
    mon_en = 1'b1;
    @(negedge clk100);
    rst = 1'b0;
    repeat (3) @(negedge clk100);
    check("post_reset_led", led_o, 3'b001);

    // Latency of a single tick
    push(2'd0, 16'd1, 3'b010);
    @(negedge clk100);
    tick_i = 1'b1;
    @(negedge clk100);
    check("lat_e1_step", step_cnt_o, 0);
    @(negedge clk100);
    check("lat_e2_step", step_cnt_o, 0);
    @(negedge clk100);
    check("lat_e3_step", step_cnt_o, 1);
    check("lat_e3_led", led_o, 3'b001);
    tick_i = 1'b0;
    @(negedge clk100);
    check("lat_e4_led", led_o, 3'b010);
    repeat (5) @(negedge clk100);

    // WALK left then right, wrapping
    push(2'd0, 16'd2, 3'b100); do_tick();
    push(2'd0, 16'd3, 3'b001); do_tick();
    dir_i = 1'b1;
    push(2'd0, 16'd4, 3'b100); do_tick();
    push(2'd0, 16'd5, 3'b010); do_tick();

    // BOUNCE
    push(2'd1, 16'd5, 3'b001); set_mode(2'd1);
    push(2'd1, 16'd6,  3'b010); do_tick();
    push(2'd1, 16'd7,  3'b100); do_tick();
    push(2'd1, 16'd8,  3'b010); do_tick();
    push(2'd1, 16'd9,  3'b001); do_tick();
    push(2'd1, 16'd10, 3'b010); do_tick();
    push(2'd1, 16'd11, 3'b100); do_tick();

    // BIN down-wrap, then GRAY
    push(2'd2, 16'd11, 3'b000); set_mode(2'd2);
    push(2'd2, 16'd12, 3'b111); do_tick();
    dir_i = 1'b0;
    push(2'd3, 16'd12, 3'b000); set_mode(2'd3);
    push(2'd3, 16'd13, 3'b001); do_tick();
    push(2'd3, 16'd14, 3'b011); do_tick();
    push(2'd3, 16'd15, 3'b010); do_tick();
    push(2'd3, 16'd16, 3'b110); do_tick();

    // Pause discards steps
    pause_i = 1'b1;
    do_tick();
    do_tick();
    check("pause_step", step_cnt_o, 16);
    check("pause_led", led_o, 3'b110);
    pause_i = 1'b0;

    // Strobe coincident with a mode change: step dropped
    push(2'd0, 16'd16, 3'b001);
    @(negedge clk100);
    tick_i = 1'b1;
    @(negedge clk100);
    @(negedge clk100);
    mode_i = 2'd0;
    @(negedge clk100);
    tick_i = 1'b0;
    repeat (5) @(negedge clk100);
    check("coincide_step", step_cnt_o, 16);
    push(2'd0, 16'd17, 3'b010); do_tick();

    // Reset one cycle after a tick rises; mode_i=BIN held across release
    mon_en = 1'b0;
    @(negedge clk100);
    tick_i = 1'b1;
    @(negedge clk100);
    rst = 1'b1;
    @(negedge clk100);
    tick_i = 1'b0;
    mode_i = 2'd2;
    repeat (2) @(negedge clk100);
    mon_en = 1'b1;
    push(2'd2, 16'd0, 3'b000);
    repeat (2) @(negedge clk100);
    rst = 1'b0;
    repeat (10) @(negedge clk100);
    check("rst_tick_step", step_cnt_o, 0);
    push(2'd2, 16'd1, 3'b001); do_tick();

    // PWM duty checks on pattern 001
    pwm_count(8'd64, 64, "pwm_duty64");
    pwm_count(8'd0, 0, "pwm_duty0");
    pwm_count(8'd255, 256, "pwm_duty255");

    // Drain and report
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk100);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
